// File: rtl/mdu_hilo_ctrl.sv
// Multiply-unit front/back end: turns MULT/MULTU into unsigned magnitudes for the
// pipelined multiplier, re-signs the product, and owns the HI/LO registers.
//
// state | meaning
// IDLE  | ready; MTHI/MTLO write directly, MULT/MULTU launch the multiplier
// WAIT  | counting down the multiplier latency; operands held
// WRITE | product valid; HI/LO loaded on the edge leaving this state
module mdu_hilo_ctrl #(
    parameter int unsigned MUL_LAT = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        op_ready,
    input  logic        flush,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b100;
    localparam logic [3:0] LAT      = 4'(MUL_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  count;
    logic        neg;
    logic        accept;
    logic        is_mul;
    logic [63:0] product;

    function automatic logic [31:0] magnitude(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    assign busy     = (state != IDLE);
    assign op_ready = !busy;
    // flush outranks a request arriving in the same cycle
    assign accept   = op_valid && op_ready && !flush;
    assign is_mul   = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign product  = neg ? (~mul_z + 64'd1) : mul_z;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_mul) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (count == 4'd0) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
                done      = !flush;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi    <= 32'd0;
            lo    <= 32'd0;
            mul_a <= 32'd0;
            mul_b <= 32'd0;
            count <= 4'd0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op_code)
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            OP_MULTU: begin
                                mul_a <= rs_val;
                                mul_b <= rt_val;
                                neg   <= 1'b0;
                                count <= LAT;
                            end
                            OP_MULT: begin
                                mul_a <= magnitude(rs_val);
                                mul_b <= magnitude(rt_val);
                                neg   <= rs_val[31] ^ rt_val[31];
                                count <= LAT;
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end
                end
                WRITE: begin
                    if (!flush) begin
                        {hi, lo} <= product;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Bench for mdu_hilo_ctrl: directed corner cases plus random ops, checked by a
// scoreboard against signed/unsigned 64-bit arithmetic and a pipelined multiplier model.
module tb_mdu_hilo_ctrl;
    localparam int MUL_LAT = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        op_ready;
    logic        flush = 1'b0;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_z;
    logic [31:0] hi, lo;
    logic        busy, done;

    always #5 clk = ~clk;

    mdu_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .flush(flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .hi(hi), .lo(lo),
        .busy(busy), .done(done)
    );

    // pipelined unsigned multiplier: product of operands sampled at an edge emerges MUL_LAT edges later
    logic [63:0] pipe [MUL_LAT];
    always @(posedge clk) begin
        pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
        for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_z = pipe[MUL_LAT-1];

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;
    bit          suppress_push = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (code == 3'b001) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [31:0] ref_mag(input logic [31:0] a);
        longint la;
        logic [63:0] u;
        la = longint'($signed(a));
        if (la < 0) la = -la;
        u = 64'(la);
        return u[31:0];
    endfunction

    // monitor: every done pulse must be matched by a queued expectation, checked after the write edge
    initial begin
        bit done_prev = 0;
        bit write_pending = 0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                done_prev = 0;
                write_pending = 0;
            end else begin
                if (write_pending) begin
                    write_pending = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got hi/lo %h%h with no multiply expected", hi, lo);
                    end else begin
                        e = exp_q.pop_front();
                        check("mul_hilo", {hi, lo}, e);
                        model_hi = e[63:32];
                        model_lo = e[31:0];
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (done_prev) begin
                        checks++;
                        errors++;
                        $display("FAIL done_width: done high %0d consecutive cycles, required 1", 2);
                    end
                    write_pending = 1;
                end
                done_prev = done;
            end
        end
    end

    task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b, input bit hold_chk);
        int n;
        logic [31:0] hi0;
        n = 0;
        @(negedge clk);
        hi0 = hi;
        op_valid = 1'b1; op_code = code; rs_val = a; rt_val = b;
        while (!op_ready && n < 60) begin
            @(negedge clk);
            n++;
            if (hold_chk && !op_ready) check("hold_hi", 64'(hi), 64'(hi0));
        end
        if (!op_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: op_ready still %0b after %0d cycles", op_ready, n);
            op_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        case (code)
            3'b001: begin
                if (!suppress_push) exp_q.push_back(ref_prod(code, a, b));
                check("mult_mul_a", 64'(mul_a), 64'(ref_mag(a)));
                check("mult_mul_b", 64'(mul_b), 64'(ref_mag(b)));
            end
            3'b010: begin
                if (!suppress_push) exp_q.push_back(ref_prod(code, a, b));
                check("multu_mul_a", 64'(mul_a), 64'(a));
                check("multu_mul_b", 64'(mul_b), 64'(b));
            end
            3'b011: begin
                model_hi = a;
                check("mthi", 64'(hi), 64'(a));
            end
            3'b100: begin
                model_lo = a;
                check("mtlo", 64'(lo), 64'(a));
            end
            default: check("nop_hilo", {hi, lo}, {model_hi, model_lo});
        endcase
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy || exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, exp_q.size());
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        logic [2:0] c;
        #12;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_mul", {mul_a, mul_b}, 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        check("rst_ready", 64'(op_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;

        // MULTU all-ones with busy-window measurement
        d0 = done_cnt;
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'd8);
        wait_idle();
        check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
        check("done_count", 64'(done_cnt - d0), 64'd1);

        issue(3'b001, 32'hFFFFFFFD, 32'h5, 0);
        wait_idle();
        check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        issue(3'b001, 32'h80000000, 32'h80000000, 0);
        wait_idle();
        check("mult_minint", {hi, lo}, 64'h40000000_00000000);
        issue(3'b001, 32'h0, 32'hFFFFFFFF, 0);
        wait_idle();
        check("mult_negzero", {hi, lo}, 64'd0);

        // MTHI stalls behind an in-flight MULT
        issue(3'b001, 32'hFFFFFFFD, 32'h5, 0);
        issue(3'b011, 32'h12345678, 32'h0, 1);
        check("mthi_after_mult", {hi, lo}, 64'h12345678_FFFFFFF1);
        wait_idle();

        // flush in the third WAIT cycle
        d0 = done_cnt;
        suppress_push = 1;
        issue(3'b010, 32'd7, 32'd9, 0);
        suppress_push = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_ready", {62'd0, op_ready, busy}, 64'd2);
        check("flush_hilo", {hi, lo}, 64'h12345678_FFFFFFF1);
        repeat (10) @(negedge clk);
        check("flush_no_done", 64'(done_cnt - d0), 64'd0);
        issue(3'b100, 32'hA5A5A5A5, 32'h0, 0);

        // flush in IDLE blocks acceptance
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'b100; rs_val = 32'h11111111; flush = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0; flush = 1'b0;
        check("idle_flush_lo", 64'(lo), 64'hA5A5A5A5);

        // asynchronous reset mid-WAIT
        suppress_push = 1;
        issue(3'b010, 32'hDEAD, 32'hBEEF, 0);
        suppress_push = 0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_mul", {mul_a, mul_b}, 64'd0);
        check("arst_busy_done", {62'd0, busy, done}, 64'd0);
        exp_q.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        issue(3'b010, 32'd2, 32'd3, 0);
        wait_idle();
        check("post_reset_mul", {hi, lo}, 64'd6);

        // random mix
        for (int k = 0; k < 60; k++) begin
            c = 3'($urandom_range(0, 7));
            issue(c, pick(), pick(), 0);
        end
        wait_idle();
        check("final_hilo", {hi, lo}, {model_hi, model_lo});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
